instr_mem_responder: RTL

Responder end of the instruction-fetch syn/ack/last handshake. It holds a word-addressed instruction store and answers a level-sensitive request (syn) from the fetch stage. It streams sequential instructions as single-cycle ack beats, ends bursts with last, and accepts PC redirects. It sits between the fetch stage and the program image, and also provides a write port for program loading.

---
 rtl/instr_mem_pkg.sv | 33 +++
 rtl/instr_mem_array.sv | 26 ++
 rtl/instr_mem_responder.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/instr_mem_pkg.sv
// rtl/instr_mem_pkg.sv - shared types, constants and parameter checks for the instruction-fetch responder
package instr_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  // RISC-V "addi x0, x0, 0", returned for fetches beyond the store
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic bit latency_ok(input int latency);
    return (latency >= 1) && (latency <= 7);
  endfunction

  function automatic bit burst_len_ok(input int burst_len);
    return (burst_len >= 1) && (burst_len <= 16);
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/instr_mem_array.sv
// rtl/instr_mem_array.sv - DEPTH x IWIDTH program store, synchronous write, asynchronous read
module instr_mem_array
  import instr_mem_pkg::*;
#(
  parameter int IWIDTH = 32,
  parameter int DEPTH  = 256,
  parameter int IDXW   = clog2(DEPTH)
) (
  input  logic              f_clk,
  input  logic              we,
  input  logic [IDXW-1:0]   waddr,
  input  logic [IWIDTH-1:0] wdata,
  input  logic [IDXW-1:0]   raddr,
  output logic [IWIDTH-1:0] rdata
);

  logic [IWIDTH-1:0] mem [DEPTH];

  // No reset: program contents must survive f_rst
  always_ff @(posedge f_clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_mem_responder.sv
// rtl/instr_mem_responder.sv - responder side of the syn/ack/last instruction-fetch handshake
module instr_mem_responder
  import instr_mem_pkg::*;
#(
  parameter int                      IWIDTH       = 32,
  parameter int                      AWIDTH_INSTR = 32,
  parameter int                      DEPTH        = 256,
  parameter int                      LATENCY      = 1,
  parameter int                      BURST_LEN    = 8,
  parameter logic [AWIDTH_INSTR-1:0] RESET_PC     = '0
) (
  input  logic                    f_clk,
  input  logic                    f_rst,
  input  logic                    m_i_syn,
  input  logic                    m_i_stall,
  input  logic                    m_i_redirect,
  input  logic [AWIDTH_INSTR-1:0] m_i_redirect_addr,
  input  logic                    m_i_we,
  input  logic [AWIDTH_INSTR-1:0] m_i_waddr,
  input  logic [IWIDTH-1:0]       m_i_wdata,
  output logic                    m_o_ack,
  output logic [IWIDTH-1:0]       m_o_instr,
  output logic [AWIDTH_INSTR-1:0] m_o_addr,
  output logic                    m_o_last,
  output logic                    m_o_err,
  output logic                    m_o_busy
);

  localparam int              IDXW     = clog2(DEPTH);
  localparam int              BCW      = clog2(BURST_LEN + 1);
  localparam logic [2:0]      LAT_INIT = 3'(LATENCY - 1);
  localparam logic [BCW-1:0]  BEAT_MAX = BCW'(BURST_LEN - 1);
  localparam logic [IDXW-1:0] IDX_MAX  = IDXW'(DEPTH - 1);

  if (!latency_ok(LATENCY) || !burst_len_ok(BURST_LEN) || !depth_ok(DEPTH)) begin : g_bad_params
    $error("instr_mem_responder: LATENCY 1..7, BURST_LEN 1..16, DEPTH power of 2");
  end

  state_t                  state, state_n;
  logic [AWIDTH_INSTR-1:0] ptr, ptr_n;
  logic [BCW-1:0]          beat_cnt, beat_cnt_n;
  logic [2:0]              lat_cnt, lat_cnt_n;
  logic                    issue;
  logic [AWIDTH_INSTR-1:0] fetch_addr;
  logic [BCW-1:0]          fetch_beat;
  logic [IDXW-1:0]         fetch_idx;
  logic                    fetch_oor, fetch_last;
  logic [IWIDTH-1:0]       rdata;
  logic                    wr_en;
  logic                    unused_addr_bits;

  assign unused_addr_bits = ^{m_i_redirect_addr[1:0], m_i_waddr[1:0]};
  assign wr_en = m_i_we && ((m_i_waddr >> (IDXW + 2)) == '0);

  instr_mem_array #(
    .IWIDTH (IWIDTH),
    .DEPTH  (DEPTH),
    .IDXW   (IDXW)
  ) u_array (
    .f_clk (f_clk),
    .we    (wr_en),
    .waddr (m_i_waddr[IDXW+1:2]),
    .wdata (m_i_wdata),
    .raddr (fetch_idx),
    .rdata (rdata)
  );

  // fetch_* describe the beat that would be registered on this edge
  assign fetch_idx  = fetch_addr[IDXW+1:2];
  assign fetch_oor  = (fetch_addr >> (IDXW + 2)) != '0;
  assign fetch_last = (fetch_beat == BEAT_MAX) || (fetch_idx == IDX_MAX) || fetch_oor;

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    beat_cnt_n = beat_cnt;
    lat_cnt_n  = lat_cnt;
    issue      = 1'b0;
    fetch_addr = ptr;
    fetch_beat = beat_cnt;
    if (m_i_redirect) begin
      ptr_n      = {m_i_redirect_addr[AWIDTH_INSTR-1:2], 2'b00};
      beat_cnt_n = '0;
      lat_cnt_n  = LAT_INIT;
      state_n    = m_i_syn ? ST_WAIT : ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (m_i_syn) begin
            state_n    = ST_WAIT;
            lat_cnt_n  = LAT_INIT;
            beat_cnt_n = '0;
          end
        end
        ST_WAIT: begin
          if (!m_i_syn) begin
            state_n = ST_IDLE;
          end else if (!m_i_stall) begin
            if (lat_cnt == 3'd0) begin
              state_n = ST_ACK;
              issue   = 1'b1;
            end else begin
              lat_cnt_n = lat_cnt - 3'd1;
            end
          end
        end
        ST_ACK: begin
          ptr_n      = ptr + AWIDTH_INSTR'(4);
          beat_cnt_n = beat_cnt + BCW'(1);
          if (m_o_last) begin
            state_n = ST_GAP;
          end else if (!m_i_syn) begin
            state_n = ST_IDLE;
          end else if (LATENCY == 1 && !m_i_stall) begin
            // Back-to-back beat straight from the incremented pointer
            state_n    = ST_ACK;
            issue      = 1'b1;
            fetch_addr = ptr_n;
            fetch_beat = beat_cnt_n;
          end else begin
            state_n   = ST_WAIT;
            lat_cnt_n = LAT_INIT;
          end
        end
        ST_GAP: state_n = ST_IDLE;
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge f_clk or negedge f_rst) begin
    if (!f_rst) begin
      state     <= ST_IDLE;
      ptr       <= RESET_PC;
      beat_cnt  <= '0;
      lat_cnt   <= '0;
      m_o_ack   <= 1'b0;
      m_o_instr <= '0;
      m_o_addr  <= '0;
      m_o_last  <= 1'b0;
      m_o_err   <= 1'b0;
      m_o_busy  <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      beat_cnt <= beat_cnt_n;
      lat_cnt  <= lat_cnt_n;
      m_o_ack  <= issue;
      m_o_busy <= (state_n == ST_WAIT) || (state_n == ST_ACK);
      if (issue) begin
        m_o_instr <= fetch_oor ? IWIDTH'(NOP_INSTR) : rdata;
        m_o_addr  <= fetch_addr;
        m_o_last  <= fetch_last;
        m_o_err   <= fetch_oor;
      end else begin
        m_o_last <= 1'b0;
        m_o_err  <= 1'b0;
      end
    end
  end

endmodule
